// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: decodes the EX/MEM memory bundle, runs the data-memory
// handshake with a bounded wait, formats load/store data and launches MEM/WB.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic [11:0] ex_mem_mem,
  input  logic [9:0]  ex_mem_wb,
  input  logic [31:0] ex_mem_alu,
  input  logic [31:0] ex_mem_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        mem_wb_valid,
  output logic [9:0]  mem_wb_wb,
  output logic [31:0] mem_wb_result,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_int, stall_int, at_limit;

  logic       mem_read, mem_write, load_unsigned;
  logic [1:0] size;
  logic       acc, bad;
  logic       unused_bits;

  assign mem_read      = ex_mem_mem[0];
  assign mem_write     = ex_mem_mem[1];
  assign size          = ex_mem_mem[3:2];
  assign load_unsigned = ex_mem_mem[4];
  assign unused_bits   = ^ex_mem_mem[11:5];

  assign acc = ex_mem_valid & (mem_read | mem_write);
  assign bad = (mem_read & mem_write) |
               (size == 2'b11) |
               ((size == 2'b01) & ex_mem_alu[0]) |
               ((size == 2'b10) & (ex_mem_alu[1:0] != 2'b00));

  assign at_limit = (cnt == TO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_int   = 1'b0;
    stall_int = 1'b0;
    case (state)
      IDLE: begin
        req_int = acc & ~bad;
        if (req_int & ~dmem_ready) begin
          stall_int = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        req_int = 1'b1;
        if (dmem_ready || at_limit) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          stall_int = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset must kill the request even before the state flop settles.
  assign dmem_req  = req_int & ~rst;
  assign mem_stall = stall_int & ~rst;
  assign dmem_we   = mem_write;
  assign dmem_addr = {ex_mem_alu[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = '0;
    if (mem_write) begin
      case (size)
        2'b00: begin
          dmem_be    = 4'b0001 << ex_mem_alu[1:0];
          dmem_wdata = {4{ex_mem_wdata[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << ex_mem_alu[1:0];
          dmem_wdata = {2{ex_mem_wdata[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = ex_mem_wdata;
        end
      endcase
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign ld_byte = dmem_rdata[{ex_mem_alu[1:0], 3'b000} +: 8];
  assign ld_half = dmem_rdata[{ex_mem_alu[1], 4'b0000} +: 16];

  always_comb begin
    load_data = dmem_rdata;
    case (size)
      2'b00: load_data = load_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01: load_data = load_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // MEM/WB launch; a stalled cycle inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb_valid  <= 1'b0;
      mem_wb_wb     <= '0;
      mem_wb_result <= '0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      if (stall_int) begin
        mem_wb_valid  <= 1'b0;
        mem_wb_wb     <= '0;
        mem_wb_result <= '0;
      end else if (state == WAIT) begin
        mem_wb_valid <= 1'b1;
        if (dmem_ready) begin
          mem_wb_wb     <= ex_mem_wb;
          mem_wb_result <= mem_read ? load_data : ex_mem_alu;
        end else begin
          mem_wb_wb     <= '0;
          mem_wb_result <= ex_mem_alu;
          bus_err       <= 1'b1;
        end
      end else if (!ex_mem_valid) begin
        mem_wb_valid  <= 1'b0;
        mem_wb_wb     <= '0;
        mem_wb_result <= '0;
      end else if (acc && bad) begin
        mem_wb_valid  <= 1'b1;
        mem_wb_wb     <= '0;
        mem_wb_result <= ex_mem_alu;
        misalign_err  <= 1'b1;
      end else begin
        mem_wb_valid  <= 1'b1;
        mem_wb_wb     <= ex_mem_wb;
        mem_wb_result <= (acc && mem_read) ? load_data : ex_mem_alu;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: loads, stores, misalignment, timeout,
// reset during a wait and back-to-back traffic.
module tb_mem_stage_ctrl;

  localparam logic [11:0] M_NONE = 12'h000;
  localparam logic [11:0] M_LW   = 12'h009;
  localparam logic [11:0] M_LB   = 12'h001;
  localparam logic [11:0] M_LBU  = 12'h011;
  localparam logic [11:0] M_LH   = 12'h005;
  localparam logic [11:0] M_LHU  = 12'h015;
  localparam logic [11:0] M_SH   = 12'h006;
  localparam logic [11:0] M_SW   = 12'h00A;
  localparam logic [11:0] M_RW   = 12'h00B;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid;
  logic [11:0] ex_mem_mem;
  logic [9:0]  ex_mem_wb;
  logic [31:0] ex_mem_alu;
  logic [31:0] ex_mem_wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall, mem_wb_valid;
  logic [9:0]  mem_wb_wb;
  logic [31:0] mem_wb_result;
  logic        misalign_err, bus_err;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_mem(ex_mem_mem), .ex_mem_wb(ex_mem_wb),
    .ex_mem_alu(ex_mem_alu), .ex_mem_wdata(ex_mem_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid), .mem_wb_wb(mem_wb_wb),
    .mem_wb_result(mem_wb_result), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] m, input logic [9:0] wb,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] rd, input logic rdy);
    ex_mem_valid = v;
    ex_mem_mem   = m;
    ex_mem_wb    = wb;
    ex_mem_alu   = alu;
    ex_mem_wdata = wd;
    dmem_rdata   = rd;
    dmem_ready   = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, M_LW, 10'h155, 32'h100, 32'h0, 32'h0, 1'b0);
    step();
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
    checks++; if ({mem_wb_valid, mem_wb_wb, mem_wb_result, misalign_err, bus_err} !== 45'h0) begin
      errors++; $display("FAIL reset_regs: got v=%b wb=%h res=%h mis=%b bus=%b expected all 0",
                         mem_wb_valid, mem_wb_wb, mem_wb_result, misalign_err, bus_err);
    end
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_lw();
    drive(1'b1, M_LW, 10'h155, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL lw_req: got %b expected 1", dmem_req); end
    checks++; if (dmem_be !== 4'b1111 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || dmem_wdata !== 32'h0) begin
      errors++; $display("FAIL lw_port: got be=%b we=%b addr=%h wd=%h expected be=1111 we=0 addr=00000100 wd=0",
                         dmem_be, dmem_we, dmem_addr, dmem_wdata);
    end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lw_stall: got %b expected 0", mem_stall); end
    step();
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (mem_wb_valid !== 1'b1 || mem_wb_result !== 32'hDEADBEEF || mem_wb_wb !== 10'h155) begin
      errors++; $display("FAIL lw_launch: got v=%b res=%h wb=%h expected v=1 res=deadbeef wb=155",
                         mem_wb_valid, mem_wb_result, mem_wb_wb);
    end
    step();
  endtask

  task automatic test_load_ext();
    drive(1'b1, M_LB, 10'h001, 32'h103, 32'h0, 32'h80123456, 1'b1);
    step();
    checks++; if (mem_wb_result !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h expected ffffff80", mem_wb_result); end
    drive(1'b1, M_LBU, 10'h001, 32'h103, 32'h0, 32'h80123456, 1'b1);
    step();
    checks++; if (mem_wb_result !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h expected 00000080", mem_wb_result); end
    drive(1'b1, M_LH, 10'h001, 32'h102, 32'h0, 32'h80123456, 1'b1);
    step();
    checks++; if (mem_wb_result !== 32'hFFFF8012) begin errors++; $display("FAIL lh_signed: got %h expected ffff8012", mem_wb_result); end
    drive(1'b1, M_LHU, 10'h001, 32'h100, 32'h0, 32'h80123456, 1'b1);
    step();
    checks++; if (mem_wb_result !== 32'h00003456) begin errors++; $display("FAIL lhu_low: got %h expected 00003456", mem_wb_result); end
    drive(1'b1, M_LBU, 10'h001, 32'h101, 32'h0, 32'h80123456, 1'b1);
    step();
    checks++; if (mem_wb_result !== 32'h00000034) begin errors++; $display("FAIL lbu_lane1: got %h expected 00000034", mem_wb_result); end
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_store_wait();
    drive(1'b1, M_SH, 10'h0AA, 32'h202, 32'h0000ABCD, 32'h0, 1'b0);
    checks++; if (dmem_addr !== 32'h200 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCDABCD || dmem_we !== 1'b1) begin
      errors++; $display("FAIL sh_port: got addr=%h be=%b wd=%h we=%b expected 00000200 1100 abcdabcd 1",
                         dmem_addr, dmem_be, dmem_wdata, dmem_we);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_stall !== 1'b1 || dmem_req !== 1'b1) begin
        errors++; $display("FAIL sh_stall%0d: got stall=%b req=%b expected 1 1", i, mem_stall, dmem_req);
      end
      step();
      checks++; if (mem_wb_valid !== 1'b0 || mem_wb_wb !== 10'h0) begin
        errors++; $display("FAIL sh_bubble%0d: got v=%b wb=%h expected 0 0", i, mem_wb_valid, mem_wb_wb);
      end
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin
      errors++; $display("FAIL sh_ready: got stall=%b req=%b expected 0 1", mem_stall, dmem_req);
    end
    step();
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (mem_wb_valid !== 1'b1 || mem_wb_wb !== 10'h0AA || mem_wb_result !== 32'h202) begin
      errors++; $display("FAIL sh_launch: got v=%b wb=%h res=%h expected 1 0aa 00000202",
                         mem_wb_valid, mem_wb_wb, mem_wb_result);
    end
    step();
    checks++; if (mem_wb_valid !== 1'b0) begin errors++; $display("FAIL sh_once: got v=%b expected 0", mem_wb_valid); end
  endtask

  task automatic test_misalign();
    drive(1'b1, M_SW, 10'h3FF, 32'h101, 32'h12345678, 32'h0, 1'b1);
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL sw_mis_req: got req=%b stall=%b expected 0 0", dmem_req, mem_stall);
    end
    step();
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (misalign_err !== 1'b1 || mem_wb_valid !== 1'b1 || mem_wb_wb !== 10'h0 || mem_wb_result !== 32'h101) begin
      errors++; $display("FAIL sw_mis_launch: got mis=%b v=%b wb=%h res=%h expected 1 1 000 00000101",
                         misalign_err, mem_wb_valid, mem_wb_wb, mem_wb_result);
    end
    step();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL sw_mis_pulse: got %b expected 0", misalign_err); end
    drive(1'b1, M_RW, 10'h3FF, 32'h100, 32'h0, 32'h0, 1'b1);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rw_req: got %b expected 0", dmem_req); end
    step();
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (misalign_err !== 1'b1 || mem_wb_wb !== 10'h0) begin
      errors++; $display("FAIL rw_mis: got mis=%b wb=%h expected 1 000", misalign_err, mem_wb_wb);
    end
    step();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    drive(1'b1, M_LW, 10'h111, 32'h300, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (mem_stall !== 1'b1) break;
      stalls++;
      step();
    end
    checks++; if (stalls != 16) begin errors++; $display("FAIL to_stall_len: got %0d expected 16", stalls); end
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL to_req_last: got %b expected 1", dmem_req); end
    step();
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (bus_err !== 1'b1 || mem_wb_valid !== 1'b1 || mem_wb_wb !== 10'h0) begin
      errors++; $display("FAIL to_launch: got bus=%b v=%b wb=%h expected 1 1 000", bus_err, mem_wb_valid, mem_wb_wb);
    end
    step();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b expected 0", bus_err); end
    drive(1'b1, M_LW, 10'h022, 32'h304, 32'h0, 32'hCAFEF00D, 1'b1);
    checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin
      errors++; $display("FAIL to_idle: got stall=%b req=%b expected 0 1", mem_stall, dmem_req);
    end
    step();
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (mem_wb_result !== 32'hCAFEF00D || mem_wb_wb !== 10'h022) begin
      errors++; $display("FAIL to_after: got res=%h wb=%h expected cafef00d 022", mem_wb_result, mem_wb_wb);
    end
    step();
  endtask

  task automatic test_reset_wait();
    drive(1'b1, M_LW, 10'h044, 32'h400, 32'h0, 32'h0, 1'b0);
    step();
    step();
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL rw_prewait: got stall=%b expected 1", mem_stall); end
    rst = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL rstw_drop: got req=%b stall=%b expected 0 0", dmem_req, mem_stall);
    end
    checks++; if ({mem_wb_valid, mem_wb_wb, mem_wb_result, misalign_err, bus_err} !== 45'h0) begin
      errors++; $display("FAIL rstw_regs: got v=%b wb=%h res=%h expected all 0", mem_wb_valid, mem_wb_wb, mem_wb_result);
    end
    step();
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    step();
    checks++; if (mem_wb_valid !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL rstw_nolaunch: got v=%b bus=%b expected 0 0", mem_wb_valid, bus_err);
    end
    drive(1'b1, M_LW, 10'h066, 32'h408, 32'h0, 32'h13572468, 1'b1);
    checks++; if (dmem_req !== 1'b1 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL rstw_fresh_req: got req=%b stall=%b expected 1 0", dmem_req, mem_stall);
    end
    step();
    drive(1'b0, M_NONE, 10'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    checks++; if (mem_wb_valid !== 1'b1 || mem_wb_result !== 32'h13572468 || mem_wb_wb !== 10'h066) begin
      errors++; $display("FAIL rstw_fresh: got v=%b res=%h wb=%h expected 1 13572468 066",
                         mem_wb_valid, mem_wb_result, mem_wb_wb);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, M_LW, 10'h101, 32'h500, 32'h0, 32'hA5A5A5A5, 1'b1);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall0: got %b expected 0", mem_stall); end
    step();
    checks++; if (mem_wb_result !== 32'hA5A5A5A5 || mem_wb_wb !== 10'h101) begin
      errors++; $display("FAIL b2b_res0: got res=%h wb=%h expected a5a5a5a5 101", mem_wb_result, mem_wb_wb);
    end
    drive(1'b1, M_LBU, 10'h102, 32'h501, 32'h0, 32'h0000AB00, 1'b1);
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall1: got %b expected 0", mem_stall); end
    step();
    checks++; if (mem_wb_result !== 32'h000000AB || mem_wb_wb !== 10'h102) begin
      errors++; $display("FAIL b2b_res1: got res=%h wb=%h expected 000000ab 102", mem_wb_result, mem_wb_wb);
    end
    drive(1'b1, M_NONE, 10'h103, 32'h00000077, 32'h0, 32'hFFFFFFFF, 1'b0);
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL b2b_alu_req: got req=%b stall=%b expected 0 0", dmem_req, mem_stall);
    end
    step();
    checks++; if (mem_wb_valid !== 1'b1 || mem_wb_result !== 32'h77 || mem_wb_wb !== 10'h103) begin
      errors++; $display("FAIL b2b_alu: got v=%b res=%h wb=%h expected 1 00000077 103", mem_wb_valid, mem_wb_result, mem_wb_wb);
    end
    drive(1'b0, M_LW, 10'h3FF, 32'h600, 32'h0, 32'h1, 1'b1);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL inv_req: got %b expected 0", dmem_req); end
    step();
    checks++; if (mem_wb_valid !== 1'b0 || mem_wb_wb !== 10'h0 || mem_wb_result !== 32'h0) begin
      errors++; $display("FAIL inv_slot: got v=%b wb=%h res=%h expected 0 000 00000000", mem_wb_valid, mem_wb_wb, mem_wb_result);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store_wait();
    test_misalign();
    test_timeout();
    test_reset_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
